// File: rtl/eq_pkg.sv
// Shared types and helpers for the equalizer I2S output stage.
package eq_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int ACC_W      = 32;
  localparam int FRAME_BITS = 2 * SAMPLE_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} tx_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] val;
    logic                clip;
  } sat_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  function automatic sat_t sat16(input logic signed [ACC_W-1:0] v);
    sat_t r;
    r.val  = v[SAMPLE_W-1:0];
    r.clip = 1'b0;
    if (v > SAT_MAX) begin
      r.val  = 16'h7FFF;
      r.clip = 1'b1;
    end else if (v < SAT_MIN) begin
      r.val  = 16'h8000;
      r.clip = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/eq_i2s_tx_if.sv
// Sample handshake between the band-sum stage and the I2S transmitter.
interface eq_i2s_tx_if
  import eq_pkg::*;
#(
  parameter int IN_W = ACC_W
);
  logic [IN_W-1:0] sample_in;
  logic            sample_valid;
  logic            sample_ready;

  modport master (output sample_in, output sample_valid, input  sample_ready);
  modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/eq_sample_fifo.sv
// First-word-fall-through sample buffer; a push into an empty FIFO is not poppable that cycle.
module eq_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/eq_i2s_tx.sv
// Band-sum scale/saturate, sample FIFO and mono I2S serializer (same sample in L and R slots).
module eq_i2s_tx
  import eq_pkg::*;
#(
  parameter int IN_W       = ACC_W,
  parameter int OUT_W      = SAMPLE_W,
  parameter int SHIFT      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int BCLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  eq_i2s_tx_if.slave s_if,
  input  logic       tx_en,
  input  logic       clr_flags,
  output logic       bclk,
  output logic       lrclk,
  output logic       sdata,
  output logic       sat_flag,
  output logic       underrun_flag
);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e              state;
  logic [DW-1:0]          div_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [FRAME_BITS-1:0]  shreg;
  logic [CW-1:0]          fifo_cnt;
  logic                   fifo_empty;
  logic [OUT_W-1:0]       fifo_dout;
  logic signed [IN_W-1:0] shifted;
  sat_t                   sat;
  logic                   push, pop, div_wrap, fall_evt, frame_start;

  assign shifted           = $signed(s_if.sample_in) >>> SHIFT;
  assign sat               = sat16(shifted);
  // rst_n is active-high here; ready is forced low for the whole reset cycle
  assign s_if.sample_ready = !rst_n && (fifo_cnt != CW'(FIFO_DEPTH));
  assign push              = s_if.sample_valid && s_if.sample_ready;

  assign div_wrap    = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall_evt    = (state != IDLE) && div_wrap && bclk;
  assign frame_start = fall_evt && (bit_cnt == '0);
  assign pop         = frame_start && (state == RUN) && !fifo_empty;

  eq_sample_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sat.val),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      bclk          <= 1'b0;
      lrclk         <= 1'b0;
      sdata         <= 1'b0;
      shreg         <= '0;
      sat_flag      <= 1'b0;
      underrun_flag <= 1'b0;
    end else begin
      sat_flag      <= (sat_flag & ~clr_flags) | (push & sat.clip);
      underrun_flag <= (underrun_flag & ~clr_flags) |
                       (frame_start && (state == RUN) && fifo_empty);
      case (state)
        IDLE: begin
          bclk    <= 1'b0;
          lrclk   <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          if (tx_en && !fifo_empty) state <= RUN;
        end
        default: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
          if (div_wrap) bclk <= ~bclk;
          if (fall_evt) begin
            // One-bit I2S delay: the k=0 slot carries the previous frame's LSB,
            // which is the MSB of the shift register after 31 shifts.
            lrclk   <= bit_cnt[BW-1];
            bit_cnt <= bit_cnt + 1'b1;
            sdata   <= shreg[FRAME_BITS-1];
            if (frame_start && (state == RUN))
              shreg <= pop ? {fifo_dout, fifo_dout} : '0;
            else
              shreg <= shreg << 1;
            if (frame_start && (state == DRAIN)) state <= IDLE;
          end
          if ((state == RUN) && !tx_en) state <= DRAIN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eq_i2s_tx.sv
// Directed/randomized bench for eq_i2s_tx: frames are rebuilt from the sample rules and compared bit-for-bit.
module tb_eq_i2s_tx;
  logic clk = 1'b0;
  logic rst_n, tx_en, clr_flags;
  logic bclk, lrclk, sdata, sat_flag, underrun_flag;

  eq_i2s_tx_if if_h ();

  eq_i2s_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_if          (if_h),
    .tx_en         (tx_en),
    .clr_flags     (clr_flags),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .sat_flag      (sat_flag),
    .underrun_flag (underrun_flag)
  );

  always #5 clk = ~clk;

  typedef struct { logic lr; logic sd; int cyc; } ev_t;
  ev_t         ev_q[$];
  logic [15:0] mq[$];
  int          cyc = 0;
  logic        bclk_q = 1'b0;
  int          total = 0, passes = 0, fails = 0;
  logic [31:0] frame_lr, frame_sd;
  int          ev_cyc[32];
  logic        prev_lsb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // every bclk 1->0 transition is one bit slot
  always @(negedge clk) begin
    if (bclk_q === 1'b1 && bclk === 1'b0) ev_q.push_back('{lrclk, sdata, cyc});
    bclk_q <= bclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint scaled(input logic [31:0] x);
    longint a = longint'($signed(x));
    return (a - (((a % 8) + 8) % 8)) / 8;  // floor(x / 8)
  endfunction

  function automatic logic [15:0] conv(input logic [31:0] x);
    longint v = scaled(x);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic clips(input logic [31:0] x);
    longint v = scaled(x);
    return (v > 32767) || (v < -32768);
  endfunction

  task automatic push(input logic [31:0] v, input logic clr, input int budget);
    logic ok = 1'b0;
    if_h.sample_in = v;
    if_h.sample_valid = 1'b1;
    clr_flags = clr;
    for (int i = 0; i < budget && !ok; i++) begin
      ok = if_h.sample_ready;
      @(negedge clk);
      clr_flags = 1'b0;
    end
    if_h.sample_valid = 1'b0;
    if (ok) mq.push_back(conv(v));
    else begin
      total++; fails++;
      $error("FAIL push_timeout: sample %0h not accepted within %0d cycles", v, budget);
    end
  endtask

  task automatic get_ev(output ev_t e);
    int t = 0;
    while (ev_q.size() == 0 && t < 64) begin @(negedge clk); t++; end
    if (ev_q.size() == 0) begin
      total++; fails++;
      $error("FAIL ev_timeout: no bclk falling edge within 64 cycles, expected one");
      e = '{1'bx, 1'bx, -1};
    end else e = ev_q.pop_front();
  endtask

  task automatic read_part(input int k0, input int k1);
    ev_t e;
    for (int k = k0; k <= k1; k++) begin
      get_ev(e);
      frame_lr[31-k] = e.lr;
      frame_sd[31-k] = e.sd;
      ev_cyc[k]      = e.cyc;
    end
  endtask

  task automatic start_frame(output logic [31:0] f);
    logic [15:0] s;
    if (mq.size() == 0) f = '0;
    else begin s = mq.pop_front(); f = {s, s}; end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] f);
    chk({tag, "_lr"}, frame_lr, 32'h0000_FFFF);
    chk({tag, "_sd"}, frame_sd, {prev_lsb, f[31:1]});
    prev_lsb = f[0];
  endtask

  initial begin
    logic [31:0] s2, s3, x, y, z, w, f;
    int c;
    ev_t e;
    rst_n = 1'b1; tx_en = 1'b0; clr_flags = 1'b0;
    if_h.sample_valid = 1'b0; if_h.sample_in = '0;
    #1 chk("ready_in_reset", 32'(if_h.sample_ready), 0);
    @(negedge clk);
    chk("outs_after_reset", {bclk, lrclk, sdata, sat_flag, underrun_flag}, 0);
    rst_n = 1'b0;
    #1 chk("ready_after_release", 32'(if_h.sample_ready), 1);
    @(negedge clk);

    // fill the FIFO with tx disabled; exercise saturation and flag clearing
    push(32'h0000_2468, 1'b0, 4);
    chk("sat_after_s0", 32'(sat_flag), 0);
    push(32'h0010_0000, 1'b1, 4);
    chk("sat_set_wins_clr", 32'(sat_flag), 1);
    clr_flags = 1'b1; @(negedge clk); clr_flags = 1'b0;
    chk("sat_cleared", 32'(sat_flag), 0);
    s2 = 32'(int'($urandom_range(0, 262143)) - 131072);
    push(s2, 1'b0, 4);
    chk("sat_inrange", 32'(sat_flag), 0);
    s3 = $urandom();
    push(s3, 1'b0, 4);
    chk("sat_random", 32'(sat_flag), 32'(clips(s3)));
    chk("ready_full", 32'(if_h.sample_ready), 0);

    // held 5th sample must land right after the first pop
    c = cyc;
    tx_en = 1'b1;
    push(32'hFFF0_0000, 1'b0, 40);
    chk("held_accept_cyc", 32'(cyc), 32'(c + 10));
    chk("sat_neg_clip", 32'(sat_flag), 1);

    for (int j = 1; j <= 5; j++) begin
      start_frame(f);
      read_part(0, 31);
      if (j == 1) begin
        chk("first_event_cyc", 32'(ev_cyc[0]), 32'(c + 9));
        chk("bclk_period", 32'(ev_cyc[1] - ev_cyc[0]), 8);
      end
      check_frame($sformatf("frame%0d", j), f);
    end

    // FIFO now empty: next frame is silence
    chk("underrun_before", 32'(underrun_flag), 0);
    x = ($urandom_range(0, 4095) << 4) | 32'h8;
    start_frame(f);
    read_part(0, 1);
    chk("underrun_set", 32'(underrun_flag), 1);
    chk("ready_after_underrun", 32'(if_h.sample_ready), 1);
    push(x, 1'b0, 4);
    read_part(2, 31);
    check_frame("frame6_underrun", f);

    // drop tx_en at k=9; the frame completes and the final slot must not pop y
    y = $urandom();
    start_frame(f);
    read_part(0, 2);
    push(y, 1'b0, 4);
    read_part(3, 9);
    tx_en = 1'b0;
    read_part(10, 31);
    check_frame("frame7_drain", f);
    get_ev(e);
    chk("drain_end_lr", 32'(e.lr), 0);
    chk("drain_end_sd", 32'(e.sd), 32'(prev_lsb));
    chk("drain_end_cyc", 32'(e.cyc - ev_cyc[31]), 8);
    repeat (40) @(negedge clk);
    chk("idle_no_events", 32'(ev_q.size()), 0);
    chk("idle_bclk_lrclk", {bclk, lrclk}, 0);
    chk("idle_sdata_hold", 32'(sdata), 32'(prev_lsb));

    // restart: y is still queued; reset lands at k=20
    prev_lsb = 1'b0;
    c = cyc;
    tx_en = 1'b1;
    start_frame(f);
    read_part(0, 3);
    chk("restart_first_cyc", 32'(ev_cyc[0]), 32'(c + 9));
    z = $urandom();
    push(z, 1'b0, 4);
    read_part(4, 20);
    chk("frame8_partial", 32'(frame_sd[31:11]), 32'({1'b0, f[31:12]}));
    rst_n = 1'b1;
    #1 chk("ready_mid_reset", 32'(if_h.sample_ready), 0);
    @(negedge clk);
    chk("outs_after_mid_reset", {bclk, lrclk, sdata, sat_flag, underrun_flag}, 0);
    rst_n = 1'b0;
    mq.delete();
    ev_q.delete();
    prev_lsb = 1'b0;
    #1 chk("ready_after_mid_reset", 32'(if_h.sample_ready), 1);
    repeat (30) @(negedge clk);
    chk("flushed_no_events", 32'(ev_q.size()), 0);

    // one more sample after the flush: only it is sent
    w = $urandom();
    c = cyc;
    push(w, 1'b0, 4);
    start_frame(f);
    read_part(0, 31);
    chk("post_reset_first_cyc", 32'(ev_cyc[0]), 32'(c + 10));
    check_frame("frame_post_reset", f);
    tx_en = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
